// File: rtl/irq_ctrl_if.sv
// Register window bundle between the MEM stage (master) and irq_ctrl (slave).
//   read_addr   master -> slave  register read address
//   write_en    master -> slave  register write strobe
//   write_addr  master -> slave  register write address
//   write_data  master -> slave  register write data
//   data_out    slave -> master  registered read data (1-cycle latency)
interface irq_ctrl_if #(
   parameter int ADDR_WIDTH = 3
);
   logic [ADDR_WIDTH-1:0] read_addr;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [31:0]           write_data;
   logic [31:0]           data_out;

   modport master (output read_addr, write_en, write_addr, write_data, input data_out);
   modport slave  (input read_addr, write_en, write_addr, write_data, output data_out);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt source for the CP0 hardware-interrupt inputs.
// Synchronizes six asynchronous peripheral requests, latches them per line in
// level or rising-edge mode, merges a Count/Compare timer into TIMER_LINE and
// drives a registered, enable-masked 6-bit vector to CP0.
//   clk        clock
//   rst        asynchronous active-low reset
//   irq_src    raw peripheral requests (asynchronous to clk)
//   bus        register window (slave side): PENDING, ENABLE, MODE, RAW, COUNT, COMPARE
//   interrupt  registered request vector to CP0
module irq_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMER_LINE  = 5,
   parameter int TIMER_DIV   = 2,
   parameter int ADDR_WIDTH  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] irq_src,
   irq_ctrl_if.slave  bus,
   output logic [5:0] interrupt
);
   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

   localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_MODE    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_RAW     = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_COUNT   = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_COMPARE = ADDR_WIDTH'(5);

   // Synchronizer chain packed as one shift register; the oldest stage is the top slice.
   logic [SYNC_STAGES*6-1:0] sync_reg;
   logic [5:0]  sync_s;
   logic [5:0]  sync_d_reg;
   logic [5:0]  pending_reg, pending_next;
   logic [5:0]  enable_reg;
   logic [5:0]  mode_reg;
   logic [5:0]  interrupt_next;
   logic [31:0] count_reg;
   logic [31:0] compare_reg;
   logic [31:0] count_inc;
   logic [PW-1:0] presc_reg;
   logic        timer_pending_reg;
   logic        tick;
   logic        wr_pending, wr_enable, wr_mode, wr_count, wr_compare;
   logic [5:0]  clr;
   logic [31:0] rd_data;

   assign sync_s = sync_reg[SYNC_STAGES*6-1 -: 6];

   assign wr_pending = bus.write_en && (bus.write_addr == A_PENDING);
   assign wr_enable  = bus.write_en && (bus.write_addr == A_ENABLE);
   assign wr_mode    = bus.write_en && (bus.write_addr == A_MODE);
   assign wr_count   = bus.write_en && (bus.write_addr == A_COUNT);
   assign wr_compare = bus.write_en && (bus.write_addr == A_COMPARE);
   assign clr        = wr_pending ? bus.write_data[5:0] : 6'd0;

   assign tick      = (presc_reg == PRE_MAX);
   assign count_inc = count_reg + 32'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_line
         // Edge mode: the rising-edge term is ORed after the clear, so a set wins.
         assign pending_next[gi] = mode_reg[gi]
            ? ((pending_reg[gi] & ~clr[gi]) | (sync_s[gi] & ~sync_d_reg[gi]))
            : sync_s[gi];
         if (gi == TIMER_LINE) begin : g_timer
            assign interrupt_next[gi] = enable_reg[gi] & (pending_reg[gi] | timer_pending_reg);
         end else begin : g_plain
            assign interrupt_next[gi] = enable_reg[gi] & pending_reg[gi];
         end
      end
   endgenerate

   // Read mux sees the pre-write register values, so same-cycle read-after-write returns old data.
   always_comb begin
      rd_data = 32'd0;
      case (bus.read_addr)
         A_PENDING: rd_data = {26'd0, pending_reg};
         A_ENABLE:  rd_data = {26'd0, enable_reg};
         A_MODE:    rd_data = {26'd0, mode_reg};
         A_RAW:     rd_data = {26'd0, sync_s};
         A_COUNT:   rd_data = count_reg;
         A_COMPARE: rd_data = compare_reg;
         default:   rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg    <= '0;
         sync_d_reg  <= '0;
         pending_reg <= '0;
         enable_reg  <= '0;
         mode_reg    <= '0;
         interrupt   <= '0;
         bus.data_out <= '0;
      end else begin
         if (SYNC_STAGES > 1) begin
            sync_reg <= {sync_reg[SYNC_STAGES*6-7:0], irq_src};
         end else begin
            sync_reg <= irq_src;
         end
         sync_d_reg  <= sync_s;
         pending_reg <= pending_next;
         if (wr_enable) enable_reg <= bus.write_data[5:0];
         if (wr_mode)   mode_reg   <= bus.write_data[5:0];
         interrupt    <= interrupt_next;
         bus.data_out <= rd_data;
      end
   end

   // Timer: a COUNT write overrides the increment, a COMPARE write overrides a match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg         <= '0;
         presc_reg         <= '0;
         compare_reg       <= 32'hFFFF_FFFF;
         timer_pending_reg <= 1'b0;
      end else begin
         if (wr_count) begin
            count_reg <= bus.write_data;
            presc_reg <= '0;
         end else if (tick) begin
            count_reg <= count_inc;
            presc_reg <= '0;
         end else begin
            presc_reg <= presc_reg + PW'(1);
         end

         if (wr_compare) begin
            compare_reg       <= bus.write_data;
            timer_pending_reg <= 1'b0;
         end else if (!wr_count && tick && (count_inc == compare_reg)) begin
            timer_pending_reg <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a cycle-level behavioural model built from
// the register map and pending/timer rules, compared every cycle, plus
// directed literal expectations for latency, W1C, timer match/wrap and async reset.
module tb_irq_ctrl;
   localparam int SYNC = 2;
   localparam int TL   = 5;
   localparam int DIV  = 2;
   localparam int AW   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] irq_src;
   logic [5:0] interrupt;

   irq_ctrl_if #(.ADDR_WIDTH(AW)) bus();

   irq_ctrl #(.SYNC_STAGES(SYNC), .TIMER_LINE(TL), .TIMER_DIV(DIV), .ADDR_WIDTH(AW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .bus       (bus),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0]  m_hist [SYNC];   // m_hist[k]: irq_src as sampled k+1 edges ago
   logic [5:0]  m_sd, m_pend, m_en, m_mode, m_int;
   logic [31:0] m_cnt, m_cmp, m_dout;
   int          m_pre;
   logic        m_tp;

   always @(posedge clk or negedge rst) begin
      logic [5:0]  s, clrv, rise;
      logic [31:0] nxt;
      logic        wr;
      int          wa;
      if (!rst) begin
         for (int k = 0; k < SYNC; k++) m_hist[k] <= '0;
         m_sd <= '0; m_pend <= '0; m_en <= '0; m_mode <= '0; m_int <= '0;
         m_cnt <= '0; m_cmp <= 32'hFFFF_FFFF; m_dout <= '0; m_pre <= 0; m_tp <= 1'b0;
      end else begin
         s  = m_hist[SYNC-1];
         wr = bus.write_en;
         wa = int'(bus.write_addr);
         case (int'(bus.read_addr))
            0: m_dout <= {26'd0, m_pend};
            1: m_dout <= {26'd0, m_en};
            2: m_dout <= {26'd0, m_mode};
            3: m_dout <= {26'd0, s};
            4: m_dout <= m_cnt;
            5: m_dout <= m_cmp;
            default: m_dout <= 32'd0;
         endcase
         m_int <= m_en & (m_pend | (m_tp ? 6'(1 << TL) : 6'd0));
         clrv = (wr && wa == 0) ? bus.write_data[5:0] : 6'd0;
         rise = s & ~m_sd;
         m_pend <= (m_mode & ((m_pend & ~clrv) | rise)) | (~m_mode & s);
         m_sd <= s;
         m_hist[0] <= irq_src;
         for (int k = 1; k < SYNC; k++) m_hist[k] <= m_hist[k-1];
         if (wr && wa == 1) m_en   <= bus.write_data[5:0];
         if (wr && wa == 2) m_mode <= bus.write_data[5:0];
         nxt = m_cnt + 32'd1;
         if (wr && wa == 4) begin
            m_cnt <= bus.write_data;
            m_pre <= 0;
         end else begin
            m_pre <= (m_pre + 1) % DIV;
            if ((m_pre + 1) % DIV == 0) begin
               m_cnt <= nxt;
               if (nxt == m_cmp) m_tp <= 1'b1;
            end
         end
         if (wr && wa == 5) begin
            m_cmp <= bus.write_data;
            m_tp  <= 1'b0;
         end
      end
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("model_interrupt", {26'd0, interrupt}, {26'd0, m_int});
         check("model_data_out", bus.data_out, m_dout);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_write(input int addr, input logic [31:0] data);
      bus.write_en   = 1'b1;
      bus.write_addr = AW'(addr);
      bus.write_data = data;
      $display("write addr=%0d data=%h t=%0t", addr, data, $time);
      @(negedge clk);
      bus.write_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      irq_src = 6'h3F;
      bus.read_addr = AW'(5);
      bus.write_en = 1'b0;
      bus.write_addr = '0;
      bus.write_data = '0;

      // Reset hold
      repeat (3) @(negedge clk);
      check("reset_interrupt", {26'd0, interrupt}, 32'd0);
      check("reset_data_out", bus.data_out, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("reset_compare", bus.data_out, 32'hFFFF_FFFF);
      irq_src = 6'h00;
      repeat (4) @(negedge clk);

      // Level latency
      do_write(1, 32'h01);
      repeat (4) @(negedge clk);
      irq_src = 6'h01;
      repeat (3) @(negedge clk);
      check("level_rise_E2", {26'd0, interrupt}, 32'h00);
      @(negedge clk);
      check("level_rise_E3", {26'd0, interrupt}, 32'h01);
      irq_src = 6'h00;
      repeat (3) @(negedge clk);
      check("level_fall_E2", {26'd0, interrupt}, 32'h01);
      @(negedge clk);
      check("level_fall_E3", {26'd0, interrupt}, 32'h00);

      // Edge mode and write-1-to-clear
      do_reset();
      do_write(2, 32'h02);
      do_write(1, 32'h02);
      irq_src = 6'h02;
      repeat (3) @(negedge clk);
      irq_src = 6'h00;
      repeat (4) @(negedge clk);
      check("edge_sticky", {26'd0, interrupt}, 32'h02);
      do_write(0, 32'h02);
      check("w1c_edge0", {26'd0, interrupt}, 32'h02);
      @(negedge clk);
      check("w1c_edge1", {26'd0, interrupt}, 32'h00);
      irq_src = 6'h02;
      repeat (2) @(negedge clk);
      do_write(0, 32'h02);   // clear strobe lands on the rising-edge cycle
      @(negedge clk);
      check("set_beats_clear", {26'd0, interrupt}, 32'h02);
      irq_src = 6'h00;

      // Timer match
      do_reset();
      do_write(1, 32'h20);
      do_write(5, 32'd10);
      do_write(4, 32'd0);
      repeat (20) @(negedge clk);
      check("timer_before", {26'd0, interrupt}, 32'h00);
      @(negedge clk);
      check("timer_match", {26'd0, interrupt}, 32'h20);
      do_write(5, 32'd100);
      check("compare_clr0", {26'd0, interrupt}, 32'h20);
      @(negedge clk);
      check("compare_clr1", {26'd0, interrupt}, 32'h00);

      // Timer wrap
      do_write(5, 32'd1);
      do_write(4, 32'hFFFF_FFFE);
      bus.read_addr = AW'(4);
      repeat (5) @(negedge clk);
      check("wrap_count_zero", bus.data_out, 32'd0);
      check("wrap_no_match0", {26'd0, interrupt}, 32'h00);
      @(negedge clk);
      check("wrap_pre_match", {26'd0, interrupt}, 32'h00);
      @(negedge clk);
      check("wrap_match1", {26'd0, interrupt}, 32'h20);

      // Async reset mid-run
      do_write(1, 32'h21);
      irq_src = 6'h01;
      repeat (5) @(negedge clk);
      check("pre_reset_vec", {26'd0, interrupt}, 32'h21);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_interrupt", {26'd0, interrupt}, 32'd0);
      check("async_data_out", bus.data_out, 32'd0);
      irq_src = 6'h00;
      bus.read_addr = AW'(5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_compare", bus.data_out, 32'hFFFF_FFFF);
      bus.read_addr = AW'(1);
      @(negedge clk);
      check("post_reset_enable", bus.data_out, 32'd0);

      // Randomized traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 3) == 0) irq_src = 6'($urandom);
         bus.read_addr = AW'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            int a;
            logic [31:0] d;
            a = $urandom_range(0, 7);
            d = $urandom;
            if (a == 5 && $urandom_range(0, 1) == 1) d = m_cnt + 32'($urandom_range(1, 6));
            if (a == 4 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(1, 6));
            do_write(a, d);
         end else begin
            @(negedge clk);
         end
         if (cyc % 997 == 500) begin
            #2 rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end
      end
      bus.write_en = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
